tag_lookup_stage: RTL

TAG_LOOKUP_STAGE -- requirements
Module: tag_lookup_stage

---
 rtl/tag_lookup_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/tag_lookup_stage.sv
// Registered tag-compare stage: a main register plus a one-entry skid buffer
// feed combinational hit/victim/status-update logic and saturating hit/miss statistics.
module tag_lookup_stage #(
  parameter int TAG_W     = 8,
  parameter int SET_W     = 4,
  parameter int OFFSET_W  = 4,
  parameter int NUM_WAYS  = 4,
  parameter int VALID_IDX = 0,
  parameter int USE_IDX   = 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [TAG_W-1:0]              i_tag,
  input  logic [SET_W-1:0]              i_set,
  input  logic [OFFSET_W-1:0]           i_offset,
  input  logic [NUM_WAYS*TAG_W-1:0]     i_ta_data,
  input  logic [2*NUM_WAYS-1:0]         i_status,
  input  logic                          i_clear,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [TAG_W-1:0]              o_tag,
  output logic [SET_W-1:0]              o_set,
  output logic [OFFSET_W-1:0]           o_offset,
  output logic [2*NUM_WAYS-1:0]         o_status,
  output logic [NUM_WAYS-1:0]           o_hit_ways,
  output logic                          o_hit,
  output logic [$clog2(NUM_WAYS)-1:0]   o_hit_idx,
  output logic                          o_multi_hit,
  output logic [$clog2(NUM_WAYS)-1:0]   o_victim_idx,
  output logic [2*NUM_WAYS-1:0]         o_status_next,
  output logic [CNT_W-1:0]              o_hit_cnt,
  output logic [CNT_W-1:0]              o_miss_cnt
);
  localparam int IDX_W = $clog2(NUM_WAYS);

  typedef struct packed {
    logic [TAG_W-1:0]          tag;
    logic [SET_W-1:0]          set;
    logic [OFFSET_W-1:0]       offset;
    logic [NUM_WAYS*TAG_W-1:0] ta;
    logic [2*NUM_WAYS-1:0]     status;
  } req_t;

  req_t              r_m;
  req_t              r_s;
  logic              r_m_valid;
  logic              r_s_valid;
  logic [IDX_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  req_t              w_in;
  logic              w_acc;
  logic              w_drain;
  logic [NUM_WAYS-1:0] w_hit_ways;
  logic              w_hit;
  logic              w_multi;
  logic [IDX_W-1:0]  w_hit_idx;
  logic              w_all_valid;
  logic              w_all_used;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic [2*NUM_WAYS-1:0] w_snext;

  // Handshake: a beat moves in when i_valid & o_ready & ~i_clear, and out when
  // o_valid & i_ready. o_ready is the inverted skid-valid flop, so it never
  // depends combinationally on i_ready.
  assign w_in    = '{tag: i_tag, set: i_set, offset: i_offset, ta: i_ta_data, status: i_status};
  assign w_acc   = i_valid & ~r_s_valid & ~i_clear;
  assign w_drain = r_m_valid & i_ready;
  assign o_ready = ~r_s_valid;
  assign o_valid = r_m_valid;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= '0;
      r_s       <= '0;
    end else if (i_clear) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (!r_m_valid || w_drain) begin
      if (r_s_valid) begin
        r_m       <= r_s;
        r_m_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else begin
        r_m_valid <= w_acc;
        if (w_acc) r_m <= w_in;
      end
    end else if (w_acc) begin
      r_s       <= w_in;
      r_s_valid <= 1'b1;
    end
  end

  always_comb begin
    w_hit_ways   = '0;
    w_hit        = 1'b0;
    w_multi      = 1'b0;
    w_hit_idx    = '0;
    w_all_valid  = 1'b1;
    w_all_used   = 1'b1;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_snext      = r_m.status;
    for (int i = 0; i < NUM_WAYS; i++) begin
      w_hit_ways[i] = r_m_valid & r_m.status[2*i+VALID_IDX] & (r_m.ta[i*TAG_W +: TAG_W] == r_m.tag);
      if (w_hit_ways[i]) begin
        if (w_hit) w_multi = 1'b1;
        else       w_hit_idx = IDX_W'(i);
        w_hit = 1'b1;
      end
      if (!r_m.status[2*i+VALID_IDX]) begin
        w_all_valid = 1'b0;
        if (!w_free_found) w_free_idx = IDX_W'(i);
        w_free_found = 1'b1;
      end
    end
    // Pseudo-LRU: once every valid way is marked used, only the latest hit keeps its mark.
    if (w_hit) begin
      for (int i = 0; i < NUM_WAYS; i++)
        if (IDX_W'(i) == w_hit_idx) w_snext[2*i+USE_IDX] = 1'b1;
      for (int i = 0; i < NUM_WAYS; i++)
        if (w_snext[2*i+VALID_IDX] && !w_snext[2*i+USE_IDX]) w_all_used = 1'b0;
      if (w_all_used)
        for (int i = 0; i < NUM_WAYS; i++)
          if (IDX_W'(i) != w_hit_idx) w_snext[2*i+USE_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ptr      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_drain) begin
      if (w_hit) begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      end else begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
        if (w_all_valid)
          r_ptr <= (r_ptr == IDX_W'(NUM_WAYS-1)) ? '0 : r_ptr + 1'b1;
      end
    end
  end

  assign o_tag         = r_m_valid ? r_m.tag    : '0;
  assign o_set         = r_m_valid ? r_m.set    : '0;
  assign o_offset      = r_m_valid ? r_m.offset : '0;
  assign o_status      = r_m_valid ? r_m.status : '0;
  assign o_hit_ways    = w_hit_ways;
  assign o_hit         = w_hit;
  assign o_hit_idx     = w_hit_idx;
  assign o_multi_hit   = w_multi;
  assign o_victim_idx  = !r_m_valid ? '0 : (w_free_found ? w_free_idx : r_ptr);
  assign o_status_next = r_m_valid ? w_snext : '0;
  assign o_hit_cnt     = r_hit_cnt;
  assign o_miss_cnt    = r_miss_cnt;

endmodule
